// File: rtl/instr_encoder.sv
// Instruction encoder: accepts one assembler-level request at a time, encodes it
// into a 32-bit ARM-style word and writes it to the next instruction-memory slot.
// Latency: accept -> ENC -> WR, so mem_we is high two cycles after the accept
// cycle. Throughput is one request per 3 cycles. req_ready is low outside IDLE,
// while full, or while clear is asserted.
// Ports: clk/rst (sync, active-high); clear; req_valid/req_ready handshake with
// req_* fields; mem_we/mem_addr/mem_wdata write port; err pulse; full; count.
module instr_encoder #(
   parameter int MEM_WORDS = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  logic        req_imm,
   input  logic [3:0]  req_rd,
   input  logic [3:0]  req_rn,
   input  logic [3:0]  req_rm,
   input  logic [7:0]  req_imm8,
   input  logic [3:0]  req_cond,
   input  logic [31:0] req_target,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        err,
   output logic        full,
   output logic [15:0] count
);

   localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_WORDS);

   localparam logic [3:0] OP_MOV = 4'd0;
   localparam logic [3:0] OP_ADD = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;
   localparam logic [3:0] OP_AND = 4'd3;
   localparam logic [3:0] OP_ORR = 4'd4;
   localparam logic [3:0] OP_CMP = 4'd5;
   localparam logic [3:0] OP_STR = 4'd6;
   localparam logic [3:0] OP_LDR = 4'd7;
   localparam logic [3:0] OP_B   = 4'd8;

   typedef enum logic [1:0] {S_IDLE, S_ENC, S_WR, S_ERR} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q;
   logic [15:0] count_q;
   logic        full_q;
   logic [31:0] wdata_q;

   // captured request fields
   logic [3:0]  op_q, rd_q, rn_q, rm_q, cond_q;
   logic        imm_q;
   logic [7:0]  imm8_q;
   logic [31:0] target_q;

   logic        accept;
   logic [31:0] enc_word;
   logic        enc_legal;
   logic [3:0]  cmd;
   logic        s_bit;
   logic [3:0]  dp_rn, dp_rd;
   logic [11:0] op2;
   logic [31:0] br_off;
   logic        unused_br;

   assign req_ready = (state_q == S_IDLE) && !full_q && !clear;
   assign accept    = req_valid && req_ready;

   assign mem_we    = (state_q == S_WR);
   assign err       = (state_q == S_ERR);
   assign mem_addr  = pc_q;
   assign mem_wdata = wdata_q;
   assign full      = full_q;
   assign count     = count_q;

   // Branch offset is relative to pc+8 (pipeline read-ahead); only word bits kept.
   assign br_off    = target_q - (pc_q + 32'd8);
   assign unused_br = ^{br_off[31:26], br_off[1:0]};

   always_comb begin
      enc_word  = 32'h0;
      enc_legal = 1'b1;
      cmd       = 4'b0000;
      s_bit     = 1'b0;
      dp_rn     = rn_q;
      dp_rd     = rd_q;
      op2       = imm_q ? {4'h0, imm8_q} : {8'h00, rm_q};
      case (op_q)
         OP_MOV: begin cmd = 4'b1101; dp_rn = 4'h0; end
         OP_ADD: cmd = 4'b0100;
         OP_SUB: cmd = 4'b0010;
         OP_AND: cmd = 4'b0000;
         OP_ORR: cmd = 4'b1100;
         OP_CMP: begin cmd = 4'b1010; s_bit = 1'b1; dp_rd = 4'h0; end
         default: cmd = 4'b0000;
      endcase
      case (op_q)
         OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_CMP:
            enc_word = {4'hE, 2'b00, imm_q, cmd, s_bit, dp_rn, dp_rd, op2};
         OP_STR, OP_LDR:
            enc_word = {4'hE, 7'b0101100, (op_q == OP_LDR), rn_q, rd_q, 4'h0, imm8_q};
         OP_B: begin
            enc_word  = {cond_q, 4'b1010, br_off[25:2]};
            enc_legal = (cond_q != 4'hF) && (target_q[1:0] == 2'b00);
         end
         default: enc_legal = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_ENC;
         S_ENC:   state_d = enc_legal ? S_WR : S_ERR;
         S_WR:    state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= 32'h0;
         count_q <= 16'h0;
         full_q  <= 1'b0;
         wdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         if (state_q == S_ENC && enc_legal) wdata_q <= enc_word;
         if (state_q == S_IDLE && clear) begin
            pc_q    <= 32'h0;
            count_q <= 16'h0;
            full_q  <= 1'b0;
         end else if (state_q == S_WR) begin
            pc_q    <= pc_q + 32'd4;
            count_q <= count_q + 16'd1;
            if (pc_q + 32'd4 == MEM_BYTES) full_q <= 1'b1;
         end
      end
   end

   // Request capture needs no reset: fields are only used after an accept.
   always_ff @(posedge clk) begin
      if (accept) begin
         op_q     <= req_op;
         imm_q    <= req_imm;
         rd_q     <= req_rd;
         rn_q     <= req_rn;
         rm_q     <= req_rm;
         imm8_q   <= req_imm8;
         cond_q   <= req_cond;
         target_q <= req_target;
      end
   end

endmodule
